// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//   Parametrised SPI master with internal chip select. Supports configurable word
//   width (MSB first), all four CPOL/CPHA modes, and multi-word bursts. CS stays
//   low between the words of a burst until a word tagged swap_last completes.
//
// Parameters
//   SCLK_FREQ, SPI_CLK_SPEED : HALF = SCLK_FREQ/(2*SPI_CLK_SPEED) sclk cycles per
//                              sck half-period (must be >= 1)
//   DATA_W                   : bits per word, 1..32
//   CPOL / CPHA              : SPI mode
//
// Ports
//   sclk, nrst      : system clock, asynchronous active-low reset
//   write_data      : word to send, captured on an accepted trigger
//   swap_trigger    : 1-cycle start request (ignored while busy)
//   swap_last       : captured with the trigger; 1 releases CS after this word
//   read_data       : received word, valid from swap_done onward
//   swap_done       : 1-cycle pulse in the last HOLD cycle of each word
//   busy            : high outside IDLE and WAIT
//   cs_n, sck, mosi : SPI pins driven by the master
//   miso            : SPI data in, sampled directly in the sclk domain
//
// Build option
//   SPI_LOOPBACK_EN : when defined, received bits are taken from mosi instead of
//                     miso; the pins still toggle normally.
// -----------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------------
// IDLE     | cs_n high, waiting for a trigger
// SETUP    | cs_n low for HALF cycles before the first sck edge
// XFER     | 2*DATA_W sck half-periods of HALF cycles each
// HOLD     | HALF cycles with sck at CPOL; swap_done on the last cycle
// WAIT     | burst pause, cs_n held low, next trigger goes straight to XFER
// RELEASE  | cs_n high for HALF cycles, then IDLE
// -----------------------------------------------------------------------------
module spi_master_param #(
   parameter int SCLK_FREQ     = 50_000_000,
   parameter int SPI_CLK_SPEED = 500_000,
   parameter int DATA_W        = 8,
   parameter bit CPOL          = 1'b0,
   parameter bit CPHA          = 1'b0
) (
   input  logic              sclk,
   input  logic              nrst,
   input  logic [DATA_W-1:0] write_data,
   input  logic              swap_trigger,
   input  logic              swap_last,
   output logic [DATA_W-1:0] read_data,
   output logic              swap_done,
   output logic              busy,
   output logic              cs_n,
   output logic              sck,
   output logic              mosi,
   input  logic              miso
);

   localparam int HALF  = SCLK_FREQ / (2 * SPI_CLK_SPEED);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int HP_W  = $clog2(2 * DATA_W);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(HALF - 1);
   localparam logic [HP_W-1:0]  HP_LAST = HP_W'(2 * DATA_W - 1);

   generate
      if (HALF < 1) begin : g_half_chk
         $error("spi_master_param: SCLK_FREQ/(2*SPI_CLK_SPEED) must be at least 1");
      end
      if (DATA_W < 1 || DATA_W > 32) begin : g_width_chk
         $error("spi_master_param: DATA_W must be within 1..32");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD,
      ST_WAIT,
      ST_RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HP_W-1:0]   hp_q, hp_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              last_q, last_d;
   logic              mosi_q, mosi_d;
   logic              sck_q, sck_d;
   logic              cs_n_q, cs_n_d;
   logic              done_q, done_d;
   logic              arm_q;

   logic              sample_bit;
   logic              cnt_tc;
   logic              start;
   logic              load;
   logic              shift_out;
   logic              sample;

`ifdef SPI_LOOPBACK_EN
   logic              miso_unused;
   assign miso_unused = miso;
   assign sample_bit  = mosi_q;
`else
   assign sample_bit  = miso;
`endif

   assign cnt_tc = (cnt_q == CNT_TC);
   // arm_q stays low for the first edge after reset release so a trigger
   // coincident with deassertion is dropped.
   assign start  = swap_trigger && arm_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hp_d        = hp_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      last_d      = last_q;
      mosi_d      = mosi_q;
      sck_d       = CPOL;
      load        = 1'b0;
      shift_out   = 1'b0;
      sample      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            hp_d  = '0;
            if (start) begin
               state_d = ST_SETUP;
               load    = 1'b1;
            end
         end
         ST_SETUP: begin
            cnt_d = cnt_tc ? '0 : cnt_q + 1'b1;
            if (cnt_tc) state_d = ST_XFER;
         end
         ST_XFER: begin
            sck_d = sck_q;
            if (cnt_tc) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               hp_d  = hp_q + 1'b1;
               // even half-period index ends on a leading edge, odd on a trailing one
               if (hp_q[0] == 1'b0) begin
                  if (CPHA) shift_out = 1'b1;
                  else      sample    = 1'b1;
               end else begin
                  if (CPHA)                  sample    = 1'b1;
                  else if (hp_q != HP_LAST)  shift_out = 1'b1;
               end
               if (hp_q == HP_LAST) begin
                  state_d = ST_HOLD;
                  hp_d    = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            cnt_d = cnt_tc ? '0 : cnt_q + 1'b1;
            if (cnt_tc) state_d = last_q ? ST_RELEASE : ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = '0;
            hp_d  = '0;
            if (start) begin
               state_d = ST_XFER;
               load    = 1'b1;
            end
         end
         ST_RELEASE: begin
            cnt_d = cnt_tc ? '0 : cnt_q + 1'b1;
            if (cnt_tc) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hp_d    = '0;
         end
      endcase

      // CPHA=0 presents the MSB before the first edge; CPHA=1 shifts it out on it
      if (load) begin
         last_d = swap_last;
         if (CPHA) begin
            tx_d = write_data;
         end else begin
            mosi_d = write_data[DATA_W-1];
            tx_d   = write_data << 1;
         end
      end
      if (shift_out) begin
         mosi_d = tx_q[DATA_W-1];
         tx_d   = tx_q << 1;
      end
      if (sample) rx_d = (rx_q << 1) | DATA_W'(sample_bit);
      if (state_d == ST_IDLE) mosi_d = 1'b0;

      cs_n_d      = (state_d == ST_IDLE) || (state_d == ST_RELEASE);
      done_d      = (state_d == ST_HOLD) && (cnt_d == CNT_TC);
      read_data_d = done_d ? rx_d : read_data_q;
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hp_q        <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         read_data_q <= '0;
         last_q      <= 1'b0;
         mosi_q      <= 1'b0;
         sck_q       <= CPOL;
         cs_n_q      <= 1'b1;
         done_q      <= 1'b0;
         arm_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hp_q        <= hp_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         read_data_q <= read_data_d;
         last_q      <= last_d;
         mosi_q      <= mosi_d;
         sck_q       <= sck_d;
         cs_n_q      <= cs_n_d;
         done_q      <= done_d;
         arm_q       <= 1'b1;
      end
   end

   assign read_data = read_data_q;
   assign swap_done = done_q;
   assign busy      = !((state_q == ST_IDLE) || (state_q == ST_WAIT));
   assign cs_n      = cs_n_q;
   assign sck       = sck_q;
   assign mosi      = mosi_q;

endmodule
